// File: rtl/seg7_bus_if.sv
// rtl/seg7_bus_if.sv - CPU data-bus port of the multiplexed 7-segment controller
interface seg7_bus_if;
    logic        enable;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] q;

    modport master (output enable, rw, addr, data, input q);
    modport slave  (input enable, rw, addr, data, output q);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - register-mapped multiplexed 7-segment scan controller
// Optional blink register and phase counter enabled by SEG7_BLINK_EN.
module seg7_scan_ctrl #(
    parameter logic [31:0] BASE          = 32'h10,
    parameter int          NDIGITS       = 4,
    parameter int          PRESCALE_BITS = 10,
    parameter int          BLINK_BITS    = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    seg7_bus_if.slave          bus,
    output logic [7:0]         seg,
    output logic [NDIGITS-1:0] an
);
    localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
`ifdef SEG7_BLINK_EN
    localparam logic [31:0] NREGS = 32'd5;
`else
    localparam logic [31:0] NREGS = 32'd4;
`endif

    typedef enum logic {SHOW, GAP} state_t;

    logic [4*NDIGITS-1:0] data_reg;
    logic [NDIGITS-1:0]   dp_reg;
    logic [NDIGITS-1:0]   blank_reg;
    logic [NDIGITS-1:0]   dark;
    logic                 run;
    logic [3:0]           bright;
    logic [PRESCALE_BITS-1:0] pre;
    logic [IDXW-1:0]      idx;
    logic [IDXW-1:0]      idx_next;
    state_t               state;
    logic [3:0]           cur_nib;
    logic                 cur_dp;
    logic [31:0]          offset;
    logic [31:0]          rdata;
    logic                 in_range;
    logic                 wr;
    logic                 rd;
    logic                 stop;
    logic                 tick;

    assign offset   = bus.addr - BASE;
    assign in_range = (bus.addr >= BASE) && (offset < NREGS);
    assign wr       = bus.enable && bus.rw && in_range;
    assign rd       = bus.enable && !bus.rw;
    // A CTRL write that clears run takes effect this edge, ahead of any tick.
    assign stop     = !run || (wr && (offset == 32'd3) && !bus.data[0]);
    assign tick     = &pre;
    assign idx_next = (idx == IDXW'(NDIGITS - 1)) ? '0 : idx + 1'b1;

`ifdef SEG7_BLINK_EN
    logic [NDIGITS-1:0]    blink_reg;
    logic [BLINK_BITS-1:0] bcnt;
    logic                  phase;
    assign dark = blank_reg | (phase ? blink_reg : '0);
`else
    assign dark = blank_reg;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
        endcase
    endfunction

    always_comb begin
        rdata = '0;
        if (in_range) begin
            case (offset[2:0])
                3'd0: rdata[4*NDIGITS-1:0] = data_reg;
                3'd1: rdata[NDIGITS-1:0]   = dp_reg;
                3'd2: rdata[NDIGITS-1:0]   = blank_reg;
                3'd3: rdata[7:0]           = {bright, 3'b000, run};
`ifdef SEG7_BLINK_EN
                3'd4: rdata[NDIGITS-1:0]   = blink_reg;
`endif
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg  <= '0;
            dp_reg    <= '0;
            blank_reg <= '0;
            run       <= 1'b1;
            bright    <= 4'hF;
            bus.q     <= '0;
`ifdef SEG7_BLINK_EN
            blink_reg <= '0;
`endif
        end else begin
            if (wr) begin
                case (offset[2:0])
                    3'd0: data_reg  <= bus.data[4*NDIGITS-1:0];
                    3'd1: dp_reg    <= bus.data[NDIGITS-1:0];
                    3'd2: blank_reg <= bus.data[NDIGITS-1:0];
                    3'd3: begin
                        run    <= bus.data[0];
                        bright <= bus.data[7:4];
                    end
`ifdef SEG7_BLINK_EN
                    3'd4: blink_reg <= bus.data[NDIGITS-1:0];
`endif
                    default: ;
                endcase
            end
            if (rd) bus.q <= rdata;
        end
    end

    // While stopped, keep digit 0 latched so a restart shows it immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre     <= '0;
            idx     <= '0;
            state   <= SHOW;
            cur_nib <= '0;
            cur_dp  <= 1'b0;
            seg     <= 8'hFF;
            an      <= '1;
`ifdef SEG7_BLINK_EN
            bcnt    <= '0;
            phase   <= 1'b0;
`endif
        end else if (stop) begin
            pre     <= '0;
            idx     <= '0;
            state   <= SHOW;
            cur_nib <= data_reg[3:0];
            cur_dp  <= dp_reg[0];
            seg     <= 8'hFF;
            an      <= '1;
        end else begin
            pre <= pre + 1'b1;
            if (tick) begin
`ifdef SEG7_BLINK_EN
                bcnt <= bcnt + 1'b1;
                if (&bcnt) phase <= ~phase;
`endif
                if (state == SHOW) begin
                    state <= GAP;
                end else begin
                    state   <= SHOW;
                    idx     <= idx_next;
                    cur_nib <= data_reg[4*idx_next +: 4];
                    cur_dp  <= dp_reg[idx_next];
                end
            end
            if (state == SHOW && !dark[idx] && pre[PRESCALE_BITS-1 -: 4] <= bright) begin
                seg <= {~cur_dp, glyph(cur_nib)};
                an  <= ~(NDIGITS'(1) << idx);
            end else begin
                seg <= 8'hFF;
                an  <= '1;
            end
        end
    end
endmodule
